i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter I2S_CLK_FREQ, default 1_500_000, target I2S bit-clock frequency in Hz.
REQ-003 Parameter DATA_SIZE, default 24, captured bits per slot (range 8..32).
REQ-004 Port clk  in  1  system clock; only clock in the block.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port en  in  1  capture enable; low halts the bus.
REQ-007 Port i2s_clk  out  1  I2S bit clock (SCK) to the microphone.
REQ-008 Port i2s_ws  out  1  word select; 0 = left slot, 1 = right slot.
REQ-009 Port i2s_sd  in  1  serial data from the microphone, asynchronous to clk.
REQ-010 Port sample_data  out  DATA_SIZE  captured sample, MSB-first order, raw two's complement.
REQ-011 Port sample_channel  out  1  slot of sample_data; 0 = left, 1 = right.
REQ-012 Port sample_valid  out  1  sample_data and sample_channel are valid.
REQ-013 Port sample_ready  in  1  downstream accepts the sample.
REQ-014 Port overrun  out  1  sticky flag: a sample was dropped.
REQ-015 Port overrun_clr  in  1  one-cycle pulse that clears overrun.

Function
REQ-016 HALF_DIV SHALL equal CLK_FREQ/(2*I2S_CLK_FREQ), computed with integer division; an elaboration check SHALL reject HALF_DIV < 4.
REQ-017 While en=1, a divider counting 0..HALF_DIV-1 SHALL toggle i2s_clk at each terminal count and SHALL generate single-cycle strobes sck_rise and sck_fall.
REQ-018 A 6-bit bit counter SHALL increment on each sck_fall and wrap from 63 to 0; one frame SHALL be 64 SCK cycles.
REQ-019 i2s_ws SHALL equal bit counter bit 5, so WS changes on SCK falling edges at counts 32 and 0.
REQ-020 i2s_sd SHALL pass through a 2-flop synchronizer.
REQ-021 Slot position p SHALL equal bit counter mod 32. At the sck_fall that ends SCK cycle p, for p in 1..DATA_SIZE, the synchronizer output SHALL shift into the sample register, MSB first (I2S one-bit delay after WS).
REQ-022 Positions 0 and DATA_SIZE+1..31 SHALL be ignored.
REQ-023 One clk after the capture of p=DATA_SIZE, the word SHALL be offered: sample_valid=1, sample_channel=WS of that slot.
REQ-024 Handshake: the transfer SHALL occur on a cycle with sample_valid & sample_ready. sample_valid, sample_data and sample_channel SHALL be held stable until that transfer. sample_valid SHALL deassert the cycle after the transfer unless a new word is offered in that same cycle.
REQ-025 If a new word completes while the previous word is still unaccepted, the new word SHALL be discarded, the held word SHALL be kept, and overrun SHALL be set.
REQ-026 If transfer and new-word completion coincide, the new word SHALL load with no overrun.
REQ-027 overrun SHALL clear on overrun_clr. If a set event and overrun_clr coincide, set SHALL win.
REQ-028 When en=0: the divider and bit counter SHALL be held at 0; i2s_clk=0; i2s_ws=0; any partial shift SHALL be discarded; a pending valid word SHALL remain until accepted.
REQ-029 On en rising, capture SHALL restart at bit count 0, left slot.

Reset
REQ-030 On rst=1 at a clk edge: i2s_clk=0, i2s_ws=0, sample_valid=0, sample_data=0, sample_channel=0, overrun=0; divider, bit counter, shift register and synchronizer SHALL all clear.
REQ-031 Reset asserted mid-frame SHALL take effect on the next clk edge; no partial sample SHALL ever be emitted.

Structure
REQ-032 Package i2s_pkg SHALL hold FRAME_BITS=64, SLOT_BITS=32, and typedef i2s_chan_e (CH_LEFT=0, CH_RIGHT=1).
REQ-033 Sub-module i2s_clkgen SHALL contain the divider, i2s_clk, and the sck_rise/sck_fall strobes. i2s_rx SHALL hold the counter, synchronizer, shift register, handshake and overrun logic.

Verification
REQ-034 Reset: assert rst for 3 clk during active capture -> all outputs 0 on the next edge; the first sample afterwards is from the left slot.
REQ-035 Clocking: defaults -> HALF_DIV=16, i2s_clk period 32 clk, i2s_ws period 2048 clk, WS edges coincident with i2s_clk falling edges.
REQ-036 Capture: mic model drives 0xA5C3F1 left and 0x800001 right, sample_ready=1 -> outputs {0xA5C3F1, ch 0} then {0x800001, ch 1}. sample_valid rises 1 clk after the 24th capture strobe; overrun stays 0.
REQ-037 Backpressure: sample_ready=0 across 2 slots -> the first word is held unchanged, the second is dropped, overrun=1. After ready=1 and an overrun_clr pulse, overrun=0 and the next word is the following left sample.
REQ-038 Coincidence: ready pulsed in the exact cycle the next word completes -> the new word loads, overrun stays 0. overrun_clr coincident with a drop -> overrun=1.
REQ-039 Enable: en dropped at bit count 10 -> next edge i2s_clk=0, i2s_ws=0, no sample emitted. Re-enable -> the first sample is the full left slot.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared frame geometry, channel encoding and slot-position helpers
//            for the I2S receiver.
// Contents : FRAME_BITS / SLOT_BITS frame geometry, counter widths,
//            i2s_chan_e channel type, slot_pos() and slot_chan() helpers.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;

  // Bit counter spans one full frame; its MSB is the word select.
  localparam int CNT_W      = $clog2(FRAME_BITS);
  // Width of the position within a slot (0..SLOT_BITS-1).
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  // Extended position needs one more bit so it can express SLOT_BITS itself.
  localparam int POS_W      = SLOT_W + 1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // Position of the current SCK cycle within its slot. Position 0 is
  // reported as SLOT_BITS: with the one-bit I2S delay, a full-width word
  // lands its LSB in the first cycle of the following slot.
  function automatic logic [POS_W-1:0] slot_pos(input logic [SLOT_W-1:0] low_cnt);
    logic [POS_W-1:0] p;
    p = POS_W'(low_cnt);
    if (low_cnt == '0) begin
      p = POS_W'(SLOT_BITS);
    end
    return p;
  endfunction

  // Channel owning the bit that finishes in the current SCK cycle. Only the
  // wrapped position (first cycle of the next slot) belongs to the slot
  // before the word-select change.
  function automatic i2s_chan_e slot_chan(input logic [CNT_W-1:0] cnt);
    logic ws;
    ws = cnt[CNT_W-1];
    if (cnt[SLOT_W-1:0] == '0) begin
      ws = ~ws;
    end
    return i2s_chan_e'(ws);
  endfunction

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clkgen
// Purpose  : Divides the system clock down to the I2S bit clock (SCK) and
//            produces single-cycle strobes aligned to each SCK edge.
// Ports    : clk         in   system clock
//            rst         in   synchronous active-high reset
//            en_i        in   run enable; low parks SCK low, divider at 0
//            sck_o       out  I2S bit clock
//            sck_rise_o  out  strobe: SCK goes high at the next clk edge
//            sck_fall_o  out  strobe: SCK goes low at the next clk edge
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clkgen #(
  parameter int HALF_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  localparam int               DIV_W = $clog2(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             w_tc;

  assign w_tc = (div_q == DIV_TC);

  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    if (!en_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (w_tc) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  // Strobes fire in the cycle before SCK changes, so logic clocked on the
  // same clk edge acts exactly when the pin toggles.
  assign sck_o      = sck_q;
  assign sck_rise_o = en_i & w_tc & ~sck_q;
  assign sck_fall_o = en_i & w_tc &  sck_q;

endmodule : i2s_clkgen
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Purpose  : I2S master receiver for a MEMS microphone. Generates SCK/WS,
//            captures serial data MSB first and offers each slot as a word
//            on a valid/ready interface, flagging dropped words.
// Ports    : clk             in   system clock (only clock)
//            rst             in   synchronous active-high reset
//            en              in   capture enable; low halts the bus
//            i2s_clk         out  I2S bit clock (SCK)
//            i2s_ws          out  word select (0 left, 1 right)
//            i2s_sd          in   serial data, asynchronous to clk
//            sample_data     out  captured word, raw two's complement
//            sample_channel  out  slot of sample_data (0 left, 1 right)
//            sample_valid    out  word on sample_data/sample_channel valid
//            sample_ready    in   downstream accepts the word
//            overrun         out  sticky: a completed word was dropped
//            overrun_clr     in   single-cycle clear of overrun
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000,
  parameter int DATA_SIZE    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  input  logic                 i2s_sd,
  output logic [DATA_SIZE-1:0] sample_data,
  output logic                 sample_channel,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int               HALF_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DATA_SIZE);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_TWO  = POS_W'(2);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (HALF_DIV < 4) begin : g_bad_half_div
      $error("i2s_rx: HALF_DIV = %0d, must be at least 4", HALF_DIV);
    end
    if ((DATA_SIZE < 8) || (DATA_SIZE > SLOT_BITS)) begin : g_bad_data_size
      $error("i2s_rx: DATA_SIZE = %0d, must be within 8..%0d", DATA_SIZE, SLOT_BITS);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bit clock generation
  // --------------------------------------------------------------------------
  logic w_sck_fall;
  // Data is both launched by the microphone and taken here on the falling
  // strobe, so the rising strobe has no consumer in this block.
  logic w_sck_rise_unused;

  i2s_clkgen #(
    .HALF_DIV (HALF_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .sck_o      (i2s_clk),
    .sck_rise_o (w_sck_rise_unused),
    .sck_fall_o (w_sck_fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sd_meta_q, sd_sync_q;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 done_q, done_d;
  i2s_chan_e            chan_pend_q, chan_pend_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  i2s_chan_e            chan_q, chan_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic [POS_W-1:0]     w_pos;
  logic                 w_take;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_drop;

  // --------------------------------------------------------------------------
  // Capture: bits enter on the falling strobe that ends their SCK cycle.
  // A word only accumulates once its first data bit (position 1) has been
  // taken, so enabling or resetting mid-slot can never yield a partial word.
  // --------------------------------------------------------------------------
  assign w_pos  = slot_pos(cnt_q[SLOT_W-1:0]);
  assign w_take = w_sck_fall &&
                  ((w_pos == POS_ONE) ||
                   (armed_q && (w_pos >= POS_TWO) && (w_pos <= LAST_POS)));
  assign w_last = w_take && (w_pos == LAST_POS);

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    done_d      = w_last;
    chan_pend_d = chan_pend_q;
    if (!en) begin
      cnt_d   = '0;
      shift_d = '0;
      armed_d = 1'b0;
    end else begin
      if (w_sck_fall) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (w_take) begin
        shift_d = {shift_q[DATA_SIZE-2:0], sd_sync_q};
        armed_d = !w_last;
      end
      // Channel is latched at the final bit: for a full-width word the
      // counter has already crossed into the next slot one cycle later.
      if (w_last) begin
        chan_pend_d = slot_chan(cnt_q);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output handshake and overrun. A completed word is offered one clk after
  // its last bit; it loads only if the holding register is free or is being
  // emptied in that same cycle, otherwise it is dropped.
  // --------------------------------------------------------------------------
  assign w_xfer = valid_q & sample_ready;
  assign w_drop = done_q & valid_q & ~sample_ready;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (w_xfer) begin
      valid_d = 1'b0;
    end
    if (done_q && !w_drop) begin
      data_d  = shift_q;
      chan_d  = chan_pend_q;
      valid_d = 1'b1;
    end
    // Set has priority over clear.
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (w_drop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sd_meta_q   <= 1'b0;
      sd_sync_q   <= 1'b0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      chan_pend_q <= CH_LEFT;
      data_q      <= '0;
      chan_q      <= CH_LEFT;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sd_meta_q   <= i2s_sd;
      sd_sync_q   <= sd_meta_q;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      chan_pend_q <= chan_pend_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign i2s_ws         = cnt_q[CNT_W-1];
  assign sample_data    = data_q;
  assign sample_channel = chan_q;
  assign sample_valid   = valid_q;
  assign overrun        = ovr_q;

endmodule : i2s_rx
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx
// Purpose  : Directed self-checking bench for i2s_rx with default parameters
//            (HALF_DIV = 16, 24-bit words) and a behavioural I2S microphone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i2s_clk;
  logic        i2s_ws;
  logic        i2s_sd;
  logic [23:0] sample_data;
  logic        sample_channel;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;

  int n_checks = 0;
  int n_errors = 0;

  i2s_rx dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .i2s_clk        (i2s_clk),
    .i2s_ws         (i2s_ws),
    .i2s_sd         (i2s_sd),
    .sample_data    (sample_data),
    .sample_channel (sample_channel),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Microphone content: slot k after enable/reset carries word k mod 8;
  // even slots are left, odd slots right.
  function automatic logic [23:0] mic_word(input int slot);
    logic [23:0] w;
    case (slot % 8)
      0:       w = 24'hA5C3F1;
      1:       w = 24'h800001;
      2:       w = 24'h123456;
      3:       w = 24'hFEDCBA;
      4:       w = 24'h7FFFFF;
      5:       w = 24'h000000;
      6:       w = 24'h5A5A5A;
      default: w = 24'hC0FFEE;
    endcase
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Microphone model: new bit after each SCK falling edge, MSB one SCK
  // cycle after a WS change.
  // --------------------------------------------------------------------------
  int   m_pos  = 0;
  int   m_slot = 0;
  logic m_prev_ws  = 1'b0;
  logic m_prev_sck = 1'b0;

  always @(negedge clk) begin
    logic [23:0] w;
    int          idx;
    if (rst || !en) begin
      m_pos     = 0;
      m_slot    = 0;
      m_prev_ws = 1'b0;
      i2s_sd    = 1'b0;
    end else if (m_prev_sck && !i2s_clk) begin
      if (i2s_ws != m_prev_ws) begin
        m_pos  = 0;
        m_slot = m_slot + 1;
      end else begin
        m_pos = m_pos + 1;
      end
      m_prev_ws = i2s_ws;
      if (m_pos >= 1 && m_pos <= 24) begin
        w      = mic_word(m_slot);
        idx    = 24 - m_pos;
        i2s_sd = w[idx[4:0]];
      end else begin
        i2s_sd = 1'b0;
      end
    end
    m_prev_sck = i2s_clk;
  end

  // WS may only change together with an SCK falling edge while running.
  int   ws_bad = 0;
  logic mon_ws_prev = 1'b0, mon_sck_prev = 1'b0, mon_en_prev = 1'b0;

  always @(negedge clk) begin
    if (en && mon_en_prev && !rst && (i2s_ws !== mon_ws_prev) &&
        !(mon_sck_prev && !i2s_clk)) begin
      ws_bad = ws_bad + 1;
    end
    mon_ws_prev  = i2s_ws;
    mon_sck_prev = i2s_clk;
    mon_en_prev  = en;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Helpers (all called from negedge context)
  // --------------------------------------------------------------------------
  task automatic wait_falls(input int n, input string tag);
    int   cnt;
    int   t;
    logic prev;
    cnt  = 0;
    t    = 0;
    prev = i2s_clk;
    while (cnt < n && t < n * 40 + 100) begin
      @(negedge clk);
      t++;
      if (prev && !i2s_clk) cnt++;
      prev = i2s_clk;
    end
    check(tag, 32'(cnt), 32'(n));
  endtask

  task automatic wait_ws_toggle(input string tag);
    logic w0;
    int   t;
    w0 = i2s_ws;
    t  = 0;
    while (i2s_ws == w0 && t < 2200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(i2s_ws), 32'(!w0));
  endtask

  task automatic get_word(input string tag, input logic [23:0] exp_d, input logic exp_c);
    int t;
    t = 0;
    while (!sample_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_v"}, 32'(sample_valid), 32'd1);
    check({tag, "_d"}, 32'(sample_data), 32'(exp_d));
    check({tag, "_c"}, 32'(sample_channel), 32'(exp_c));
    @(negedge clk);
  endtask

  task automatic restart(input logic rdy);
    sample_ready = 1'b1;
    en           = 1'b0;
    repeat (4) @(negedge clk);
    sample_ready = rdy;
    en           = 1'b1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_sck"},   32'(i2s_clk),        32'd0);
    check({pfx, "_ws"},    32'(i2s_ws),         32'd0);
    check({pfx, "_valid"}, 32'(sample_valid),   32'd0);
    check({pfx, "_data"},  32'(sample_data),    32'd0);
    check({pfx, "_chan"},  32'(sample_channel), 32'd0);
    check({pfx, "_ovr"},   32'(overrun),        32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int   per;
    int   hi;
    int   t;
    int   seen;
    logic prev;
    logic rose;

    rst          = 1'b1;
    en           = 1'b0;
    sample_ready = 1'b0;
    overrun_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // ---- capture: left then right, valid one clk after the 24th capture
    sample_ready = 1'b1;
    en           = 1'b1;
    wait_falls(25, "cap_falls");
    check("cap_valid_early", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("cap_valid_lat", 32'(sample_valid), 32'd1);
    check("cap_l_d", 32'(sample_data), 32'hA5C3F1);
    check("cap_l_c", 32'(sample_channel), 32'd0);
    @(negedge clk);
    get_word("cap_r", 24'h800001, 1'b1);
    check("cap_ovr", 32'(overrun), 32'd0);

    // ---- clocking: SCK period/high time, WS period
    prev = i2s_clk;
    t    = 0;
    rose = 1'b0;
    while (!rose && t < 100) begin
      @(negedge clk);
      t++;
      rose = !prev && i2s_clk;
      prev = i2s_clk;
    end
    per  = 0;
    hi   = 1;
    rose = 1'b0;
    while (!rose && per < 100) begin
      @(negedge clk);
      per++;
      rose = !prev && i2s_clk;
      if (!rose && i2s_clk) hi++;
      prev = i2s_clk;
    end
    check("sck_period", 32'(per), 32'd32);
    check("sck_high", 32'(hi), 32'd16);

    prev = i2s_ws;
    t    = 0;
    rose = 1'b0;
    while (!rose && t < 2200) begin
      @(negedge clk);
      t++;
      rose = !prev && i2s_ws;
      prev = i2s_ws;
    end
    per  = 0;
    rose = 1'b0;
    while (!rose && per < 2200) begin
      @(negedge clk);
      per++;
      rose = !prev && i2s_ws;
      prev = i2s_ws;
    end
    check("ws_period", 32'(per), 32'd2048);

    // ---- backpressure: hold first word, drop second, then clear
    restart(1'b0);
    get_word("bp_first", 24'hA5C3F1, 1'b0);
    t = 0;
    while (!overrun && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("bp_ovr", 32'(overrun), 32'd1);
    check("bp_hold_v", 32'(sample_valid), 32'd1);
    check("bp_hold_d", 32'(sample_data), 32'hA5C3F1);
    check("bp_hold_c", 32'(sample_channel), 32'd0);
    sample_ready = 1'b1;
    @(negedge clk);
    check("bp_vdrop", 32'(sample_valid), 32'd0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("bp_ovr_clr", 32'(overrun), 32'd0);
    get_word("bp_next_l", 24'h123456, 1'b0);
    get_word("bp_next_r", 24'hFEDCBA, 1'b1);

    // ---- coincidence: ready in the load cycle, then clear during a drop
    restart(1'b0);
    get_word("co_first", 24'hA5C3F1, 1'b0);
    wait_ws_toggle("co_ws1");
    wait_falls(25, "co_falls1");
    check("co_pre_d", 32'(sample_data), 32'hA5C3F1);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("co_new_v", 32'(sample_valid), 32'd1);
    check("co_new_d", 32'(sample_data), 32'h800001);
    check("co_new_c", 32'(sample_channel), 32'd1);
    check("co_new_ovr", 32'(overrun), 32'd0);
    wait_ws_toggle("co_ws2");
    wait_falls(25, "co_falls2");
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("co_clr_set", 32'(overrun), 32'd1);
    check("co_drop_d", 32'(sample_data), 32'h800001);
    check("co_drop_c", 32'(sample_channel), 32'd1);

    // ---- reset mid-frame with a held word and overrun pending
    wait_falls(15, "rst_falls");
    check("rst_pre_ws", 32'(i2s_ws), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    sample_ready = 1'b1;
    get_word("rst_first", 24'hA5C3F1, 1'b0);

    // ---- enable dropped at bit count 10
    restart(1'b1);
    wait_falls(10, "en10_falls");
    repeat (20) @(negedge clk);
    check("en10_pre_sck", 32'(i2s_clk), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("en10_sck", 32'(i2s_clk), 32'd0);
    check("en10_ws", 32'(i2s_ws), 32'd0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid) seen++;
    end
    check("en10_noval", 32'(seen), 32'd0);

    // ---- enable dropped at bit count 42 (right slot)
    en = 1'b1;
    wait_falls(42, "en42_falls");
    repeat (20) @(negedge clk);
    check("en42_pre_ws", 32'(i2s_ws), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("en42_sck", 32'(i2s_clk), 32'd0);
    check("en42_ws", 32'(i2s_ws), 32'd0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid) seen++;
    end
    check("en42_noval", 32'(seen), 32'd0);

    en = 1'b1;
    get_word("en_first_l", 24'hA5C3F1, 1'b0);
    get_word("en_first_r", 24'h800001, 1'b1);
    check("en_ovr", 32'(overrun), 32'd0);

    check("ws_on_fall", 32'(ws_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_i2s_rx
`default_nettype wire
